// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the scan test sequencer: FSM state encoding
// and the default MISR feedback polynomial.
package scan_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SHIFT,
      CAPTURE,
      FLUSH,
      DONE
   } state_t;

   localparam logic [15:0] SIG_POLY_DEFAULT = 16'h8016;

endpackage

// File: rtl/scan_misr.sv
// Serial-input signature register: one response bit per enabled cycle is folded
// into an SIG_W-bit LFSR using SIG_POLY as the feedback taps.
module scan_misr
#(
   parameter int               SIG_W    = 16,
   parameter logic [SIG_W-1:0] SIG_POLY = 16'h8016
) (
   input  logic             i_ck,
   input  logic             i_reset_n,
   input  logic             i_clear,
   input  logic             i_en,
   input  logic             i_data,
   output logic [SIG_W-1:0] o_sig
);

   logic [SIG_W-1:0] r_sig;
   logic [SIG_W-1:0] w_sig_next;

   // Shift left, fold the outgoing MSB back through the taps, inject data at bit 0.
   assign w_sig_next = (r_sig << 1)
                     ^ (r_sig[SIG_W-1] ? SIG_POLY : {SIG_W{1'b0}})
                     ^ {{(SIG_W-1){1'b0}}, i_data};

   always_ff @(posedge i_ck or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sig <= '0;
      end else if (i_clear) begin
         r_sig <= '0;
      end else if (i_en) begin
         r_sig <= w_sig_next;
      end
   end

   assign o_sig = r_sig;

endmodule

// File: rtl/scan_test_sequencer.sv
// Scan test sequencer: loads patterns into a scan chain, captures, and unloads/compares
// responses with load N+1 overlapping unload N. Optional MISR enabled by SCAN_MISR_EN.
module scan_test_sequencer
   import scan_seq_pkg::*;
#(
   parameter int               CHAIN_LEN = 3,
   parameter int               PI_W      = 4,
   parameter int               PO_W      = 1,
   parameter int               CNT_W     = 16,
   parameter int               SIG_W     = 16,
   parameter logic [SIG_W-1:0] SIG_POLY  = SIG_W'(SIG_POLY_DEFAULT)
) (
   input  logic                 CK,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 pat_valid,
   output logic                 pat_ready,
   input  logic [CHAIN_LEN-1:0] pat_scan,
   input  logic [PI_W-1:0]      pat_pi,
   input  logic [PO_W-1:0]      pat_po_exp,
   input  logic [CHAIN_LEN-1:0] pat_ff_exp,
   input  logic                 pat_last,
   output logic                 cut_ce,
   output logic                 cut_scan_en,
   output logic                 cut_scan_in,
   input  logic                 cut_scan_out,
   output logic [PI_W-1:0]      cut_pi,
   input  logic [PO_W-1:0]      cut_po,
   output logic                 busy,
   output logic                 done,
   output logic                 fail,
   output logic [CNT_W-1:0]     fail_count,
   output logic [CNT_W-1:0]     first_fail_idx,
   output logic [SIG_W-1:0]     misr_sig
);

   localparam int K_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [K_W-1:0]         r_k;
   logic [CHAIN_LEN-1:0]   r_sh;
   logic [PI_W-1:0]        r_pat_pi;
   logic [PO_W-1:0]        r_pat_po_exp;
   logic [CHAIN_LEN-1:0]   r_pat_ff_exp;
   logic                   r_pat_last;
   logic [CHAIN_LEN-1:0]   r_exp_sh;
   logic                   r_have_prev;
   logic                   r_pend_mis;
   logic [CNT_W-1:0]       r_idx;
   logic [CNT_W-1:0]       r_prev_idx;
   logic [PI_W-1:0]        r_pi_hold;
   logic                   r_done;
   logic                   r_fail;
   logic [CNT_W-1:0]       r_fail_count;
   logic [CNT_W-1:0]       r_first_fail;

   logic w_start_go;
   logic w_accept;
   logic w_k_last;
   logic w_cmp_bit;
   logic w_bit_mis;
   logic w_po_mis;
   logic w_pat_fail;

   assign w_start_go = (r_state == IDLE) && start;
   assign w_accept   = (r_state == FETCH) && pat_valid;
   assign w_k_last   = (r_k == K_W'(CHAIN_LEN - 1));
   // Unload compares only once a captured response sits in the chain.
   assign w_cmp_bit  = ((r_state == SHIFT) && r_have_prev) || (r_state == FLUSH);
   assign w_bit_mis  = w_cmp_bit && (cut_scan_out != r_exp_sh[CHAIN_LEN-1]);
   assign w_po_mis   = (r_state == CAPTURE) && (cut_po != r_pat_po_exp);
   assign w_pat_fail = w_cmp_bit && w_k_last && (r_pend_mis || w_bit_mis);

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (start)     w_state_next = FETCH;
         FETCH:   if (pat_valid) w_state_next = SHIFT;
         SHIFT:   if (w_k_last)  w_state_next = CAPTURE;
         CAPTURE: w_state_next = r_pat_last ? FLUSH : FETCH;
         FLUSH:   if (w_k_last)  w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge CK or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_k          <= '0;
         r_sh         <= '0;
         r_pat_pi     <= '0;
         r_pat_po_exp <= '0;
         r_pat_ff_exp <= '0;
         r_pat_last   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if ((r_state == SHIFT) || (r_state == FLUSH)) begin
            r_k <= w_k_last ? '0 : r_k + 1'b1;
         end else begin
            r_k <= '0;
         end
         if (w_accept) begin
            r_sh         <= pat_scan;
            r_pat_pi     <= pat_pi;
            r_pat_po_exp <= pat_po_exp;
            r_pat_ff_exp <= pat_ff_exp;
            r_pat_last   <= pat_last;
         end else if (r_state == SHIFT) begin
            r_sh <= r_sh << 1;
         end
      end
   end

   // A pattern's verdict is PO at its capture plus every bit of its later unload.
   always_ff @(posedge CK or negedge reset_n) begin
      if (!reset_n) begin
         r_exp_sh     <= '0;
         r_have_prev  <= 1'b0;
         r_pend_mis   <= 1'b0;
         r_idx        <= '0;
         r_prev_idx   <= '0;
         r_pi_hold    <= '0;
         r_done       <= 1'b0;
         r_fail       <= 1'b0;
         r_fail_count <= '0;
         r_first_fail <= '0;
      end else if (w_start_go) begin
         r_have_prev  <= 1'b0;
         r_pend_mis   <= 1'b0;
         r_idx        <= '0;
         r_done       <= 1'b0;
         r_fail       <= 1'b0;
         r_fail_count <= '0;
         r_first_fail <= '0;
      end else begin
         if (r_state == CAPTURE) begin
            r_exp_sh    <= r_pat_ff_exp;
            r_pi_hold   <= r_pat_pi;
            r_pend_mis  <= w_po_mis;
            r_have_prev <= 1'b1;
            r_prev_idx  <= r_idx;
            r_idx       <= r_idx + 1'b1;
         end else if (w_cmp_bit) begin
            r_exp_sh   <= r_exp_sh << 1;
            r_pend_mis <= r_pend_mis || w_bit_mis;
         end
         if ((r_state == FLUSH) && w_k_last) begin
            r_done <= 1'b1;
         end
         if (w_pat_fail) begin
            r_fail <= 1'b1;
            if (r_fail_count != {CNT_W{1'b1}}) begin
               r_fail_count <= r_fail_count + 1'b1;
            end
            if (!r_fail) begin
               r_first_fail <= r_prev_idx;
            end
         end
      end
   end

   assign pat_ready      = (r_state == FETCH);
   assign cut_ce         = (r_state == SHIFT) || (r_state == CAPTURE) || (r_state == FLUSH);
   assign cut_scan_en    = (r_state == SHIFT) || (r_state == FLUSH);
   assign cut_scan_in    = (r_state == SHIFT) && r_sh[CHAIN_LEN-1];
   assign cut_pi         = (r_state == CAPTURE) ? r_pat_pi : r_pi_hold;
   assign busy           = (r_state != IDLE) && (r_state != DONE);
   assign done           = r_done;
   assign fail           = r_fail;
   assign fail_count     = r_fail_count;
   assign first_fail_idx = r_first_fail;

`ifdef SCAN_MISR_EN
   logic w_misr_en;
   logic w_misr_bit;

   assign w_misr_en  = w_cmp_bit || (r_state == CAPTURE);
   assign w_misr_bit = (r_state == CAPTURE) ? ^cut_po : cut_scan_out;

   scan_misr #(
      .SIG_W    (SIG_W),
      .SIG_POLY (SIG_POLY)
   ) u_misr (
      .i_ck      (CK),
      .i_reset_n (reset_n),
      .i_clear   (w_start_go),
      .i_en      (w_misr_en),
      .i_data    (w_misr_bit),
      .o_sig     (misr_sig)
   );
`else
   // No signature hardware: output held at zero (masking keeps the polynomial referenced).
   assign misr_sig = SIG_POLY & {SIG_W{1'b0}};
`endif

endmodule
